// File: rtl/memory_pkg.sv
// memory_pkg: shared size encoding, state encoding and lane-index helpers for memory_lanes
package memory_pkg;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE} size_e;
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    function automatic int size_bytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    // Which request byte lane j carries when the access starts in lane a_lo.
    function automatic int lane_offset(input int j, input int a_lo, input int lanes);
        return (j + lanes - a_lo) % lanes;
    endfunction

    // Which lane holds request byte k when the access starts in lane a_lo.
    function automatic int lane_of(input int a_lo, input int k, input int lanes);
        return (a_lo + k) % lanes;
    endfunction
endpackage

// File: rtl/ramOnChip.sv
// ramOnChip: single-port RAM with synchronous read (read-before-write)
// clk: clock; we/addr/wdata: write port; rdata: registered read of addr
module ramOnChip #(
    parameter int ramWide = 8,
    parameter int ramSize = 8192
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(ramSize)-1:0] addr,
    input  logic [ramWide-1:0]         wdata,
    output logic [ramWide-1:0]         rdata
);
    logic [ramWide-1:0] mem [ramSize];
    logic [ramWide-1:0] rdata_q;

    assign rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= mem[addr];
    end
endmodule

// File: rtl/memory_lanes.sv
// memory_lanes: byte-lane banked memory, any-alignment access, two-stage read pipeline
// Clk, Reset: clock and synchronous active-high reset
// Req, Wr, Size, Unsigned, Address, Datain: request, taken when Ready=1
// Valid, Fault, Dataout: read result or fault pulse two cycles after acceptance
module memory_lanes
    import memory_pkg::*;
#(
    parameter int LANES          = 8,
    parameter int ROW_BITS       = 13,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Req,
    input  logic               Wr,
    input  logic [1:0]         Size,
    input  logic               Unsigned,
    input  logic [63:0]        Address,
    input  logic [8*LANES-1:0] Datain,
    output logic               Ready,
    output logic               Valid,
    output logic [8*LANES-1:0] Dataout,
    output logic               Fault
);
    localparam int LB = $clog2(LANES);
    localparam int AW = LB + ROW_BITS;
    localparam int W  = 8 * LANES;
    localparam int WB = $clog2(W);

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] clr_q, clr_d;
    logic                s1_v_q, s1_v_d, s1_f_q, s1_f_d, s1_uns_q, s1_uns_d;
    logic [LB-1:0]       s1_off_q, s1_off_d;
    logic [1:0]          s1_size_q, s1_size_d;
    logic                valid_q, valid_d, fault_q, fault_d;
    logic [W-1:0]        dout_q, dout_d, rot, ext;
    logic [LB-1:0]       li;
    logic [WB-1:0]       sb;
    logic                accept, fault_req, clearing, wr_ok, unused_addr;
    logic [7:0]          rbyte [LANES];

    assign unused_addr = ^Address[63:AW];
    assign Ready       = state_q == ST_RUN;
    assign Valid       = valid_q;
    assign Fault       = fault_q;
    assign Dataout     = dout_q;

    always_comb begin
        fault_req = size_bytes(Size) > LANES;
        accept    = Req & Ready & ~Reset;
        clearing  = (state_q == ST_CLEAR) & ~Reset;
        wr_ok     = accept & Wr & ~fault_req;
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [LB-1:0]       off;
        logic [AW-1:0]       b;
        logic                we;
        logic [ROW_BITS-1:0] row;
        logic [7:0]          wd;
        always_comb begin
            off = LB'(lane_offset(j, 32'(Address[LB-1:0]), LANES));
            b   = Address[AW-1:0] + AW'(off);
            we  = clearing | (wr_ok & (32'(off) < size_bytes(Size)));
            row = clearing ? clr_q : b[AW-1:LB];
            wd  = clearing ? 8'd0 : Datain[{off, 3'b000} +: 8];
        end
        ramOnChip #(.ramWide(8), .ramSize(2 ** ROW_BITS)) u_ram (
            .clk  (Clk),
            .we   (we),
            .addr (row),
            .wdata(wd),
            .rdata(rbyte[j])
        );
    end

    always_comb begin
        clr_d     = state_q == ST_CLEAR ? clr_q + 1'b1 : clr_q;
        state_d   = state_q == ST_CLEAR && &clr_q ? ST_RUN : state_q;
        s1_v_d    = accept & (~Wr | fault_req);
        s1_f_d    = accept & fault_req;
        s1_off_d  = Address[LB-1:0];
        s1_size_d = Size;
        s1_uns_d  = Unsigned;
        rot = '0;
        li  = '0;
        for (int k = 0; k < LANES; k++) begin
            li = LB'(lane_of(32'(s1_off_q), k, LANES));
            rot[8*k +: 8] = rbyte[li];
        end
        // Bits past the access width take the fill; a full-width access never reaches the fill.
        sb  = WB'(8 * size_bytes(s1_size_q) - 1);
        ext = '0;
        for (int i = 0; i < W; i++) ext[i] = i < 8 * size_bytes(s1_size_q) ? rot[i] : ~s1_uns_q & rot[sb];
        valid_d = s1_v_q;
        fault_d = s1_f_q;
        dout_d  = s1_v_q & ~s1_f_q ? ext : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_q   <= '0;
            s1_v_q  <= 1'b0;
            s1_f_q  <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            s1_v_q  <= s1_v_d;
            s1_f_q  <= s1_f_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            dout_q  <= dout_d;
        end
        s1_off_q  <= s1_off_d;
        s1_size_q <= s1_size_d;
        s1_uns_q  <= s1_uns_d;
    end
endmodule

// File: tb/tb_memory_lanes.sv
// tb_memory_lanes: randomized scoreboard bench for memory_lanes, LANES=8 and LANES=4 instances
module tb_memory_lanes;
    typedef struct {
        int          d;
        int          due;
        logic [63:0] v;
        logic        f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        req [2];
    logic        wr [2];
    logic        uns [2];
    logic [1:0]  size [2];
    logic [63:0] addr [2];
    logic [63:0] din [2];
    logic        ready [2];
    logic        valid [2];
    logic        fault [2];
    logic [63:0] dout8;
    logic [31:0] dout4;
    logic [7:0]  mem [2][512];
    exp_t        q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_lanes #(.LANES(8), .ROW_BITS(6), .CLEAR_ON_RESET(1'b1)) dut8 (
        .Clk(clk), .Reset(rst), .Req(req[0]), .Wr(wr[0]), .Size(size[0]), .Unsigned(uns[0]),
        .Address(addr[0]), .Datain(din[0]), .Ready(ready[0]), .Valid(valid[0]), .Dataout(dout8),
        .Fault(fault[0])
    );

    memory_lanes #(.LANES(4), .ROW_BITS(4), .CLEAR_ON_RESET(1'b1)) dut4 (
        .Clk(clk), .Reset(rst), .Req(req[1]), .Wr(wr[1]), .Size(size[1]), .Unsigned(uns[1]),
        .Address(addr[1]), .Datain(din[1][31:0]), .Ready(ready[1]), .Valid(valid[1]), .Dataout(dout4),
        .Fault(fault[1])
    );

    function automatic logic [63:0] dout_of(input int d);
        return d != 0 ? {32'd0, dout4} : dout8;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-array reference: capacity wraps, reads assemble little-endian then extend.
    task automatic model(input int d, input logic w, input logic [1:0] s, input logic u,
                         input logic [63:0] a, input logic [63:0] dt,
                         output logic [63:0] v, output logic f);
        int l;
        int cap;
        int n;
        int idx;
        l   = d != 0 ? 4 : 8;
        cap = d != 0 ? 64 : 512;
        n   = 1 << s;
        v   = 64'd0;
        f   = n > l;
        if (f) return;
        for (int k = 0; k < n; k++) begin
            idx = int'((a + 64'(k)) % 64'(cap));
            if (w) mem[d][idx] = dt[8*k +: 8];
            else v[8*k +: 8] = mem[d][idx];
        end
        if (!w && n < l && !u && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        if (l < 8) v = v & ((64'd1 << (8*l)) - 64'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req[0] = 1'b0;
        req[1] = 1'b0;
    endtask

    task automatic issue(input int d, input logic w, input logic [1:0] s, input logic u,
                         input logic [63:0] a, input logic [63:0] dt,
                         input logic use_k = 1'b0, input logic [63:0] k = 64'd0);
        exp_t e;
        @(posedge clk); #1;
        req[0] = 1'b0;
        req[1] = 1'b0;
        req[d] = 1'b1;
        wr[d] = w;
        size[d] = s;
        uns[d] = u;
        addr[d] = a;
        din[d] = dt;
        check("ready", 64'(ready[d]), 64'd1);
        model(d, w, s, u, a, dt, e.v, e.f);
        if (use_k) e.v = k;
        e.d = d;
        e.due = cyc + 2;
        if (e.f || !w) q.push_back(e);
    endtask

    task automatic do_reset();
        int n;
        @(posedge clk); #1;
        rst = 1'b1;
        req[0] = 1'b0;
        req[1] = 1'b0;
        while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 512; i++) mem[d][i] = 8'd0;
        check("rst_valid", 64'(valid[0]), 64'd0);
        check("rst_fault", 64'(fault[0]), 64'd0);
        check("rst_dout", dout8, 64'd0);
        mon_en = 1'b1;
        n = 0;
        while (!ready[0] && n < 1000) begin
            n++;
            @(posedge clk); #1;
        end
        check("clear_cycles", 64'(n), 64'd64);
        check("ready4", 64'(ready[1]), 64'd1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (q.size() > 0 && q[0].due == cyc && q[0].d == d) begin
                    check($sformatf("valid%0d", d), 64'(valid[d]), 64'd1);
                    check($sformatf("fault%0d", d), 64'(fault[d]), 64'(q[0].f));
                    check($sformatf("dout%0d", d), dout_of(d), q[0].v);
                    void'(q.pop_front());
                end else if (valid[d]) begin
                    check($sformatf("spurious_valid%0d", d), 64'(valid[d]), 64'd0);
                end
            end
        end
    end

    initial begin
        int dsel;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0;
            wr[d] = 1'b0;
            uns[d] = 1'b0;
            size[d] = 2'd0;
            addr[d] = 64'd0;
            din[d] = 64'd0;
        end
        do_reset();
        issue(0, 1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 1'b1, 64'd0);
        issue(0, 1'b1, 2'd3, 1'b0, 64'h13, 64'h8877665544332211);
        issue(0, 1'b0, 2'd0, 1'b0, 64'h1A, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF88);
        issue(0, 1'b0, 2'd1, 1'b1, 64'h17, 64'd0, 1'b1, 64'h6655);
        issue(0, 1'b1, 2'd2, 1'b0, 64'h0, 64'hDEADBEEF);
        issue(0, 1'b0, 2'd2, 1'b0, 64'h0, 64'd0, 1'b1, 64'hFFFFFFFFDEADBEEF);
        issue(0, 1'b1, 2'd3, 1'b0, 64'd508, 64'h0807060504030201);
        issue(0, 1'b0, 2'd2, 1'b1, 64'h0, 64'd0, 1'b1, 64'h08070605);
        issue(0, 1'b0, 2'd2, 1'b1, 64'd508, 64'd0, 1'b1, 64'h04030201);
        issue(1, 1'b1, 2'd2, 1'b0, 64'h8, 64'hCAFEF00D);
        issue(1, 1'b1, 2'd3, 1'b0, 64'h8, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd0);
        issue(1, 1'b0, 2'd3, 1'b0, 64'h8, 64'd0, 1'b1, 64'd0);
        issue(1, 1'b0, 2'd2, 1'b0, 64'h8, 64'd0, 1'b1, 64'hCAFEF00D);
        issue(1, 1'b0, 2'd1, 1'b0, 64'hA, 64'd0, 1'b1, 64'hFFFFCAFE);
        for (int it = 0; it < 600; it++) begin
            dsel = $urandom_range(0, 3) == 0 ? 1 : 0;
            if ($urandom_range(0, 4) == 0) idle();
            issue(dsel, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom});
        end
        issue(0, 1'b0, 2'd3, 1'b0, 64'h0, 64'd0);
        issue(0, 1'b0, 2'd2, 1'b1, 64'h8, 64'd0);
        issue(0, 1'b0, 2'd1, 1'b0, 64'h10, 64'd0);
        do_reset();
        issue(0, 1'b0, 2'd3, 1'b0, 64'h1F8, 64'd0, 1'b1, 64'd0);
        repeat (6) idle();
        check("drain", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
